cpu_bus_write_fifo: RTL and testbench
=====================================

// Module: cpu_bus_write_fifo
// PURPOSE
//  Stage downstream of the CPU bus slave port: captures CPU write strobes (EN&WE) on BUS_CLK,
//  filters them by BRAM_SELECT and queues {select, addr, data} in a FIFO.
//  Drains the queue to the BRAM/register-file write stage over a valid/ready handshake,
//  so a busy consumer never loses CPU writes until the queue overflows.
// PARAMETERS
//  DEPTH        16       FIFO entries; power of two, 2..64
//  SELECT_MASK  4'b1111  bit i=1 -> writes with BRAM_SELECT==i are accepted
//  CTL_LIMIT    14'h0100 first illegal BRAM_ADDR for select 0 (used only with range check)
// PORTS
//  BUS_CLK      in   1   bus clock; all logic on its rising edge
//  RST_N        in   1   asynchronous, active-low reset
//  EN           in   1   bus enable
//  WE           in   1   bus write enable
//  BRAM_SELECT  in   2   target BRAM
//  BRAM_ADDR    in   14  word address
//  DATA_IN      in   16  write data
//  M_VALID      out  1   queued write present on M_*
//  M_READY      in   1   consumer accepts the write on M_*
//  M_SELECT     out  2   queued BRAM_SELECT
//  M_ADDR       out  14  queued BRAM_ADDR
//  M_DATA       out  16  queued DATA_IN
//  LEVEL        out  $clog2(DEPTH)+1  entries held, including the one on M_*
//  OVERFLOW     out  1   sticky: a qualified write was dropped because the FIFO was full
//  OVF_CLR      in   1   clears OVERFLOW
//  ERR_CNT      out  8   range-check drop counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: M_VALID=0, M_SELECT/M_ADDR/M_DATA=0, LEVEL=0, OVERFLOW=0, ERR_CNT=0, pointers=0.
//   Reset mid-drain discards all entries; nothing is replayed.
//  Push: a cycle with EN&WE&SELECT_MASK[BRAM_SELECT] (and range legal) is qualified; it is
//   written at that edge. EN&!WE (read) is ignored.
//  Pop: a cycle with M_VALID&M_READY. M_* advance to the next entry at that edge.
//  Latency: when the FIFO is empty, a push at edge N gives M_VALID=1 with its data after
//   edge N (first-word-fall-through, registered output). No combinational in->out path.
//  Stability: while M_VALID&!M_READY, M_* hold their values. M_VALID never drops without a pop.
//  Order: strict FIFO. No coalescing of repeated addresses.
//  FSM of the output stage:
//   EMPTY -push-> VALID
//   VALID -pop & LEVEL==1 & !push-> EMPTY
//   VALID -pop & (LEVEL>1 | push)-> VALID with next data. A push into an empty FIFO with
//   simultaneous pop is impossible (M_VALID=0).
//  Full (LEVEL==DEPTH):
//   - push without pop: write dropped, OVERFLOW<=1, LEVEL unchanged
//   - push with pop: both succeed, LEVEL stays DEPTH, no overflow
//  LEVEL: +1 on push-only, -1 on pop-only, unchanged on both or neither; never exceeds DEPTH.
//  Pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.
//  OVF_CLR and a new overflow in the same cycle: OVERFLOW ends 1 (set wins).
// CONFIGURATION
//  Macro CPU_BUS_ADDR_RANGE_CHECK_EN:
//   defined: a write with BRAM_SELECT==0 and BRAM_ADDR>=CTL_LIMIT is not queued.
//    ERR_CNT+=1 for it, saturating at 8'hFF. A range drop never sets OVERFLOW.
//   undefined: no address check is applied. ERR_CNT is tied to 0.
// TESTING
//  1 Reset, then one write sel=1 addr=14'h0012 data=16'hBEEF with M_READY=1
//    -> M_VALID=1 for exactly 1 cycle, the cycle after the write edge, with those values.
//    LEVEL goes 1 then 0.
//  2 M_READY=0, 16 writes data=0..15
//    -> LEVEL=16, OVERFLOW=0. Then a 17th write: dropped, OVERFLOW=1.
//    Then M_READY=1: data out 0..15 in order, then M_VALID=0.
//  3 Full FIFO, a write in the same cycle as a pop
//    -> LEVEL stays 16, OVERFLOW stays 0, the new entry emerges last.
//  4 SELECT_MASK=4'b0001, writes with sel=2 and an EN=1,WE=0 read
//    -> nothing queued, LEVEL=0, M_VALID=0.
//  5 Range check (macro defined): sel=0 addr=14'h0100 -> dropped, ERR_CNT=1.
//    sel=0 addr=14'h00FF -> queued. 300 illegal writes -> ERR_CNT=8'hFF.
//  6 RST_N low for 1 cycle while LEVEL=5 and M_VALID&!M_READY
//    -> every output returns to its reset value asynchronously. The old data never reappears.

Source files
------------

// File: rtl/cpu_bus_write_fifo_if.sv
// Bus bundle for cpu_bus_write_fifo: CPU write capture side and valid/ready drain side.
// The slave modport is the FIFO's view; master is the environment's view.
interface cpu_bus_write_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          EN;
    logic          WE;
    logic [1:0]    BRAM_SELECT;
    logic [13:0]   BRAM_ADDR;
    logic [15:0]   DATA_IN;
    logic          M_VALID;
    logic          M_READY;
    logic [1:0]    M_SELECT;
    logic [13:0]   M_ADDR;
    logic [15:0]   M_DATA;
    logic [LW-1:0] LEVEL;
    logic          OVERFLOW;
    logic          OVF_CLR;
    logic [7:0]    ERR_CNT;

    modport slave (
        input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, M_READY, OVF_CLR,
        output M_VALID, M_SELECT, M_ADDR, M_DATA, LEVEL, OVERFLOW, ERR_CNT
    );

    modport master (
        output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN, M_READY, OVF_CLR,
        input  M_VALID, M_SELECT, M_ADDR, M_DATA, LEVEL, OVERFLOW, ERR_CNT
    );
endinterface

// File: rtl/cpu_bus_write_fifo.sv
// Queues filtered CPU bus writes and drains them first-word-fall-through over valid/ready.
// Optional address range check on select 0 enabled by macro CPU_BUS_ADDR_RANGE_CHECK_EN.
module cpu_bus_write_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [3:0]  SELECT_MASK = 4'b1111,
    parameter logic [13:0] CTL_LIMIT   = 14'h0100
) (
    input  logic                   BUS_CLK,
    input  logic                   RST_N,
    cpu_bus_write_fifo_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [15:0] data;
    } wr_entry_t;

    typedef enum logic {ST_EMPTY = 1'b0, ST_VALID = 1'b1} state_t;

    state_t    state_q, state_d;
    wr_entry_t head_q, head_d;
    wr_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] rd_nidx;
    wr_entry_t in_entry;
    logic      wr_strobe, push_req, push, pop, full, ovf_set;

    assign in_entry  = '{sel: bus.BRAM_SELECT, addr: bus.BRAM_ADDR, data: bus.DATA_IN};
    assign wr_strobe = bus.EN & bus.WE & SELECT_MASK[bus.BRAM_SELECT];

`ifdef CPU_BUS_ADDR_RANGE_CHECK_EN
    logic       range_bad;
    logic [7:0] err_q;

    assign range_bad = (bus.BRAM_SELECT == 2'd0) && (bus.BRAM_ADDR >= CTL_LIMIT);
    assign push_req  = wr_strobe & ~range_bad;

    // Saturating count of writes rejected by the range check
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N)                                  err_q <= 8'h00;
        else if (wr_strobe && range_bad && err_q != 8'hFF) err_q <= err_q + 8'(1);
    end
    assign bus.ERR_CNT = err_q;
`else
    logic unused_range;
    assign unused_range = ^CTL_LIMIT;
    assign push_req     = wr_strobe;
    assign bus.ERR_CNT  = 8'h00;
`endif

    // Full when pointers differ only in the wrap bit
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = (state_q == ST_VALID) & bus.M_READY;
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;
    assign rd_nidx = rd_q[AW-1:0] + AW'(1);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_VALID;
                    head_d  = in_entry;
                end
            end
            ST_VALID: begin
                if (pop) begin
                    if (level_q != LW'(1)) head_d  = mem_q[rd_nidx];
                    else if (push)         head_d  = in_entry;
                    else                   state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (push) wr_d = wr_q + PW'(1);
        if (pop)  rd_d = rd_q + PW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        if (bus.OVF_CLR) ovf_d = 1'b0;
        if (ovf_set)     ovf_d = 1'b1;
    end

    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge BUS_CLK) begin
        if (push) mem_q[wr_q[AW-1:0]] <= in_entry;
    end

    assign bus.M_VALID  = (state_q == ST_VALID);
    assign bus.M_SELECT = head_q.sel;
    assign bus.M_ADDR   = head_q.addr;
    assign bus.M_DATA   = head_q.data;
    assign bus.LEVEL    = level_q;
    assign bus.OVERFLOW = ovf_q;
endmodule

// File: tb/tb_cpu_bus_write_fifo.sv
// Randomized + directed bench for cpu_bus_write_fifo against a queue-based reference model.
// Honours CPU_BUS_ADDR_RANGE_CHECK_EN the same way as the design.
module tb_cpu_bus_write_fifo;
    localparam int unsigned DEPTH = 16;
    localparam logic [13:0] CTL_LIMIT = 14'h0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_write_fifo_if #(.DEPTH(DEPTH)) bus0 ();
    cpu_bus_write_fifo_if #(.DEPTH(DEPTH)) bus1 ();

    cpu_bus_write_fifo #(.DEPTH(DEPTH), .SELECT_MASK(4'b1111), .CTL_LIMIT(CTL_LIMIT)) dut0 (
        .BUS_CLK(clk), .RST_N(rst_n), .bus(bus0.slave));
    cpu_bus_write_fifo #(.DEPTH(DEPTH), .SELECT_MASK(4'b0001), .CTL_LIMIT(CTL_LIMIT)) dut1 (
        .BUS_CLK(clk), .RST_N(rst_n), .bus(bus1.slave));

    typedef struct packed {
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [15:0] data;
    } ent_t;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    ent_t     mq[$];
    bit       m_ovf = 1'b0;
    int       m_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the accept/drop rules applied at each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_err = 0;
        end else begin
            int  sz;
            bit  pop, wr, bad;
            sz  = mq.size();
            pop = (sz > 0) && bus0.M_READY;
            wr  = bus0.EN && bus0.WE;
`ifdef CPU_BUS_ADDR_RANGE_CHECK_EN
            bad = (bus0.BRAM_SELECT == 2'd0) && (bus0.BRAM_ADDR >= CTL_LIMIT);
`else
            bad = 1'b0;
`endif
            if (pop) void'(mq.pop_front());
            if (bus0.OVF_CLR) m_ovf = 1'b0;
            if (wr && bad) begin
                if (m_err < 255) m_err++;
            end else if (wr) begin
                if (sz < DEPTH || pop)
                    mq.push_back('{sel: bus0.BRAM_SELECT, addr: bus0.BRAM_ADDR, data: bus0.DATA_IN});
                else
                    m_ovf = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("m_valid", 64'(bus0.M_VALID), 64'(mq.size() != 0));
            if (mq.size() != 0)
                chk("m_word", 64'({bus0.M_SELECT, bus0.M_ADDR, bus0.M_DATA}), 64'(mq[0]));
            chk("level", 64'(bus0.LEVEL), 64'(mq.size()));
            chk("overflow", 64'(bus0.OVERFLOW), 64'(m_ovf));
            chk("err_cnt", 64'(bus0.ERR_CNT), 64'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input bit en, input bit we, input logic [1:0] sel,
                       input logic [13:0] addr, input logic [15:0] data, input bit rdy);
        bus0.EN = en; bus0.WE = we; bus0.BRAM_SELECT = sel;
        bus0.BRAM_ADDR = addr; bus0.DATA_IN = data; bus0.M_READY = rdy;
    endtask

    task automatic drv1(input bit en, input bit we, input logic [1:0] sel, input logic [13:0] addr);
        bus1.EN = en; bus1.WE = we; bus1.BRAM_SELECT = sel;
        bus1.BRAM_ADDR = addr; bus1.DATA_IN = 16'h1234;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
        bus0.OVF_CLR = 1'b0;
        drv1(0, 0, 2'd0, 14'h0);
        bus1.OVF_CLR = 1'b0;
        bus1.M_READY = 1'b0;
        do_reset();
        chk_on = 1'b1;

        chk("rst_valid", 64'(bus0.M_VALID), 64'(0));
        chk("rst_level", 64'(bus0.LEVEL), 64'(0));
        chk("rst_word", 64'({bus0.M_SELECT, bus0.M_ADDR, bus0.M_DATA}), 64'(0));

        // Single write with ready high: visible for exactly one cycle
        drv(1, 1, 2'd1, 14'h0012, 16'hBEEF, 1);
        step();
        drv(0, 0, 2'd0, 14'h0, 16'h0, 1);
        chk("t1_valid", 64'(bus0.M_VALID), 64'(1));
        chk("t1_word", 64'({bus0.M_SELECT, bus0.M_ADDR, bus0.M_DATA}), 64'({2'd1, 14'h0012, 16'hBEEF}));
        chk("t1_level1", 64'(bus0.LEVEL), 64'(1));
        step();
        chk("t1_valid_off", 64'(bus0.M_VALID), 64'(0));
        chk("t1_level0", 64'(bus0.LEVEL), 64'(0));

        // Fill to full, then one overflowing write
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 2'd1, 14'(i), 16'(i), 0);
            step();
        end
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
        chk("t2_full_level", 64'(bus0.LEVEL), 64'(16));
        chk("t2_no_ovf", 64'(bus0.OVERFLOW), 64'(0));
        chk("t2_head", 64'(bus0.M_DATA), 64'(0));
        drv(1, 1, 2'd1, 14'h3F, 16'h0099, 0);
        step();
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
        chk("t2_ovf", 64'(bus0.OVERFLOW), 64'(1));
        chk("t2_ovf_level", 64'(bus0.LEVEL), 64'(16));
        bus0.OVF_CLR = 1'b1;
        step();
        bus0.OVF_CLR = 1'b0;
        chk("ovf_clr", 64'(bus0.OVERFLOW), 64'(0));

        // Full: push with pop in the same cycle
        drv(1, 1, 2'd2, 14'h0123, 16'hAAAA, 1);
        step();
        drv(0, 0, 2'd0, 14'h0, 16'h0, 1);
        chk("t3_level", 64'(bus0.LEVEL), 64'(16));
        chk("t3_no_ovf", 64'(bus0.OVERFLOW), 64'(0));
        for (int i = 1; i < 16; i++) begin
            chk("t3_drain", 64'(bus0.M_DATA), 64'(i));
            step();
        end
        chk("t3_last", 64'(bus0.M_DATA), 64'(16'hAAAA));
        chk("t3_last_valid", 64'(bus0.M_VALID), 64'(1));
        step();
        chk("t3_empty", 64'(bus0.M_VALID), 64'(0));

        // Select mask filtering and reads ignored on the second instance
        drv1(1, 1, 2'd2, 14'h0005);
        step();
        drv1(1, 0, 2'd0, 14'h0005);
        step();
        drv1(1, 1, 2'd3, 14'h0006);
        step();
        drv1(0, 0, 2'd0, 14'h0);
        chk("t4_level", 64'(bus1.LEVEL), 64'(0));
        chk("t4_valid", 64'(bus1.M_VALID), 64'(0));
        drv1(1, 1, 2'd0, 14'h0005);
        step();
        drv1(0, 0, 2'd0, 14'h0);
        chk("t4_sel0_level", 64'(bus1.LEVEL), 64'(1));
        chk("t4_sel0_word", 64'({bus1.M_SELECT, bus1.M_ADDR, bus1.M_DATA}), 64'({2'd0, 14'h0005, 16'h1234}));

        // Range check boundary
        drv(1, 1, 2'd0, 14'h0100, 16'h5555, 0);
        step();
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
`ifdef CPU_BUS_ADDR_RANGE_CHECK_EN
        chk("t5_err1", 64'(bus0.ERR_CNT), 64'(1));
        chk("t5_drop", 64'(bus0.LEVEL), 64'(0));
        drv(1, 1, 2'd0, 14'h00FF, 16'h6666, 0);
        step();
        chk("t5_legal", 64'(bus0.LEVEL), 64'(1));
        for (int i = 0; i < 300; i++) begin
            drv(1, 1, 2'd0, 14'(32'h0100 + 32'(i)), 16'(i), 1);
            step();
        end
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
        chk("t5_sat", 64'(bus0.ERR_CNT), 64'(8'hFF));
        chk("t5_no_ovf", 64'(bus0.OVERFLOW), 64'(0));
`else
        chk("t5_err_tied", 64'(bus0.ERR_CNT), 64'(0));
        chk("t5_queued", 64'(bus0.LEVEL), 64'(1));
`endif

        // Randomized traffic with varying consumer backpressure
        for (int c = 0; c < 4000; c++) begin
            int pr;
            logic [13:0] a;
            pr = (c / 400) % 3 == 0 ? 10 : ((c / 400) % 3 == 1 ? 50 : 90);
            a  = ($urandom_range(0, 9) < 3) ? 14'(32'h00F8 + $urandom_range(0, 15)) : 14'($urandom);
            drv($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, 2'($urandom), a,
                16'($urandom), $urandom_range(0, 99) < pr);
            bus0.OVF_CLR = $urandom_range(0, 99) < 3;
            step();
        end
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
        bus0.OVF_CLR = 1'b0;

        // Asynchronous reset while holding 5 entries under backpressure
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 2'd3, 14'(i + 40), 16'(i + 16'hC0), 0);
            step();
        end
        drv(0, 0, 2'd0, 14'h0, 16'h0, 0);
        chk("t6_level5", 64'(bus0.LEVEL), 64'(5));
        chk("t6_held", 64'(bus0.M_DATA), 64'(16'hC0));
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(bus0.M_VALID), 64'(0));
        chk("t6_async_level", 64'(bus0.LEVEL), 64'(0));
        chk("t6_async_word", 64'({bus0.M_SELECT, bus0.M_ADDR, bus0.M_DATA}), 64'(0));
        chk("t6_async_flags", 64'({bus0.OVERFLOW, bus0.ERR_CNT}), 64'(0));
        step();
        rst_n = 1'b1;
        bus0.M_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_replay", 64'(bus0.M_VALID), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
